// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: walks IDLE/FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// owns the shared memory port, counts retired instructions and halts on faults.
// Ports: clk, rst (async, active-high); opcode, branch_taken, mem_ready in;
//   mem_req/mem_we/mem_addr_sel, ir/mdr/pc write, pc_src, alu_a/b_sel,
//   reg_write, wb_sel, state, halted, fault, instret out.
// Option: define CTRL_TIMEOUT_EN to build the memory-wait timeout (fault=10).
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_write,
    output logic                 mdr_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [1:0]           fault,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXE   = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_fault, w_fault_next;
    logic [INSTRET_W-1:0]  r_instret;
    logic                  w_retire;
    logic                  w_req;
    logic                  w_timeout;

    logic w_lui, w_auipc, w_jal, w_jalr, w_br;
    logic w_load, w_store, w_opimm, w_op, w_fence, w_sys;
    logic w_legal;

    assign w_lui   = (opcode == 7'b0110111);
    assign w_auipc = (opcode == 7'b0010111);
    assign w_jal   = (opcode == 7'b1101111);
    assign w_jalr  = (opcode == 7'b1100111);
    assign w_br    = (opcode == 7'b1100011);
    assign w_load  = (opcode == 7'b0000011);
    assign w_store = (opcode == 7'b0100011);
    assign w_opimm = (opcode == 7'b0010011);
    assign w_op    = (opcode == 7'b0110011);
    assign w_fence = (opcode == 7'b0001111);
    assign w_sys   = (opcode == 7'b1110011);
    assign w_legal = w_lui | w_auipc | w_jal | w_jalr | w_br | w_load |
                     w_store | w_opimm | w_op | w_fence | w_sys;

`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_wait;

    // Any cycle that is not an unanswered request resets the count, so
    // the counter is always zero on entry to FETCH or MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wait <= '0;
        else if (w_req && !mem_ready)
            r_wait <= r_wait + 1'b1;
        else
            r_wait <= '0;
    end

    // True in the waiting cycle that brings the count to the limit.
    assign w_timeout = (r_wait == LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_fault   <= 2'b00;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_fault <= w_fault_next;
            if (w_retire)
                r_instret <= r_instret + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_fault_next = r_fault;
        w_retire     = 1'b0;
        w_req        = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        halted       = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_DEC;
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_fault_next = 2'b10;
                end
            end
            S_DEC: begin
                if (w_legal) begin
                    w_next = S_EXE;
                end else begin
                    w_next       = S_HALT;
                    w_fault_next = 2'b01;
                end
            end
            S_EXE: begin
                unique case (1'b1)
                    w_op, w_lui, w_jal: w_next = S_WB;
                    w_opimm, w_jalr: begin
                        alu_b_sel = 1'b1;
                        w_next    = S_WB;
                    end
                    w_auipc: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        w_next    = S_WB;
                    end
                    w_load, w_store: begin
                        alu_b_sel = 1'b1;
                        w_next    = S_MEM;
                    end
                    w_br: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    w_fence: begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    w_sys: begin
                        w_next       = S_HALT;
                        w_fault_next = 2'b11;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                w_req        = 1'b1;
                mem_addr_sel = 1'b1;
                alu_b_sel    = 1'b1;
                mem_we       = w_store;
                if (mem_ready) begin
                    if (w_store) begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        mdr_write = 1'b1;
                        w_next    = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_fault_next = 2'b10;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
                if (w_lui)
                    wb_sel = 2'b11;
                else if (w_load)
                    wb_sel = 2'b01;
                else if (w_jal || w_jalr)
                    wb_sel = 2'b10;
                if (w_jal)
                    pc_src = 2'b01;
                else if (w_jalr)
                    pc_src = 2'b10;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_HALT;
        endcase
    end

    // Reset is asynchronous, so the request is gated directly by it.
    assign mem_req = w_req & ~rst;
    assign state   = r_state;
    assign fault   = r_fault;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand-written sequences for halt hold, async reset and memory timeout.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write;
    logic [1:0]  pc_src, wb_sel, fault;
    logic        alu_a_sel, alu_b_sel, reg_write, halted;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(15), .INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
        .halted(halted), .fault(fault), .instret(instret)
    );

    // {state, req, we, addr, ir, mdr, pcw, pc_src, a, b, rw, wb_sel, halted, fault}
    localparam logic [18:0] ZERO = 19'b000_000000_00_000_00_0_00;
    localparam logic [18:0] F_RD = 19'b001_100100_00_000_00_0_00;
    localparam logic [18:0] F_WT = 19'b001_100000_00_000_00_0_00;
    localparam logic [18:0] DEC  = 19'b010_000000_00_000_00_0_00;
    localparam logic [18:0] E_NO = 19'b011_000000_00_000_00_0_00;
    localparam logic [18:0] E_B  = 19'b011_000000_00_010_00_0_00;
    localparam logic [18:0] E_AB = 19'b011_000000_00_110_00_0_00;
    localparam logic [18:0] E_BT = 19'b011_000001_01_000_00_0_00;
    localparam logic [18:0] E_P4 = 19'b011_000001_00_000_00_0_00;
    localparam logic [18:0] M_LW = 19'b100_101000_00_010_00_0_00;
    localparam logic [18:0] M_LR = 19'b100_101010_00_010_00_0_00;
    localparam logic [18:0] M_SR = 19'b100_111001_00_010_00_0_00;
    localparam logic [18:0] W_AL = 19'b101_000001_00_001_00_0_00;
    localparam logic [18:0] W_LD = 19'b101_000001_00_001_01_0_00;
    localparam logic [18:0] W_JL = 19'b101_000001_01_001_10_0_00;
    localparam logic [18:0] W_JR = 19'b101_000001_10_001_10_0_00;
    localparam logic [18:0] W_LU = 19'b101_000001_00_001_11_0_00;
    localparam logic [18:0] H_SY = 19'b110_000000_00_000_00_1_11;
    localparam logic [18:0] H_IL = 19'b110_000000_00_000_00_1_01;
    localparam logic [18:0] H_TO = 19'b110_000000_00_000_00_1_10;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUIP = 7'b0010111;
    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] FEN  = 7'b0001111;
    localparam logic [6:0] SYS  = 7'b1110011;
    localparam logic [6:0] BAD  = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic        tk;
        logic [18:0] exp;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] outs();
        return {state, mem_req, mem_we, mem_addr_sel, ir_write, mdr_write,
                pc_write, pc_src, alu_a_sel, alu_b_sel, reg_write, wb_sel,
                halted, fault};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic rd,
                       input logic t, input logic [18:0] e,
                       input logic [31:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = rd; v.tk = t; v.exp = e; v.ret = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Apply inputs at the falling edge, sample 1ns later.
    task automatic step(input logic r, input logic [6:0] o, input logic rd,
                        input logic t);
        @(negedge clk);
        rst = r; opcode = o; mem_ready = rd; branch_taken = t;
        #1;
    endtask

    initial begin
        add(1, ADDI, 0, 0, ZERO, 0);
        add(0, ADDI, 0, 0, ZERO, 0);
        add(0, ADDI, 1, 0, F_RD, 0);
        add(0, ADDI, 1, 0, DEC,  0);
        add(0, ADDI, 1, 0, E_B,  0);
        add(0, ADDI, 1, 0, W_AL, 0);
        add(0, LW,   1, 0, F_RD, 1);
        add(0, LW,   0, 0, DEC,  1);
        add(0, LW,   0, 0, E_B,  1);
        add(0, LW,   0, 0, M_LW, 1);
        add(0, LW,   0, 0, M_LW, 1);
        add(0, LW,   0, 0, M_LW, 1);
        add(0, LW,   1, 0, M_LR, 1);
        add(0, LW,   0, 0, W_LD, 1);
        add(0, BR,   1, 1, F_RD, 2);
        add(0, BR,   0, 1, DEC,  2);
        add(0, BR,   0, 1, E_BT, 2);
        add(0, BR,   1, 0, F_RD, 3);
        add(0, BR,   0, 0, DEC,  3);
        add(0, BR,   0, 0, E_P4, 3);
        add(0, SW,   0, 0, F_WT, 4);
        add(0, SW,   1, 0, F_RD, 4);
        add(0, SW,   0, 0, DEC,  4);
        add(0, SW,   0, 0, E_B,  4);
        add(0, SW,   1, 0, M_SR, 4);
        add(0, JAL,  1, 0, F_RD, 5);
        add(0, JAL,  0, 0, DEC,  5);
        add(0, JAL,  0, 0, E_NO, 5);
        add(0, JAL,  0, 0, W_JL, 5);
        add(0, JALR, 1, 0, F_RD, 6);
        add(0, JALR, 0, 0, DEC,  6);
        add(0, JALR, 0, 0, E_B,  6);
        add(0, JALR, 0, 0, W_JR, 6);
        add(0, LUI,  1, 0, F_RD, 7);
        add(0, LUI,  0, 0, DEC,  7);
        add(0, LUI,  0, 0, E_NO, 7);
        add(0, LUI,  0, 0, W_LU, 7);
        add(0, AUIP, 1, 0, F_RD, 8);
        add(0, AUIP, 0, 0, DEC,  8);
        add(0, AUIP, 0, 0, E_AB, 8);
        add(0, AUIP, 0, 0, W_AL, 8);
        add(0, OP,   1, 0, F_RD, 9);
        add(0, OP,   0, 0, DEC,  9);
        add(0, OP,   0, 0, E_NO, 9);
        add(0, OP,   0, 0, W_AL, 9);
        add(0, FEN,  1, 0, F_RD, 10);
        add(0, FEN,  0, 0, DEC,  10);
        add(0, FEN,  0, 0, E_P4, 10);
        add(0, SYS,  1, 0, F_RD, 11);
        add(0, SYS,  0, 0, DEC,  11);
        add(0, SYS,  0, 0, E_NO, 11);
        add(0, SYS,  1, 0, H_SY, 11);
        add(0, SYS,  1, 0, H_SY, 11);
        add(1, BAD,  1, 0, ZERO, 0);
        add(0, BAD,  1, 0, ZERO, 0);
        add(0, BAD,  1, 0, F_RD, 0);
        add(0, BAD,  1, 0, DEC,  0);
        add(0, BAD,  1, 0, H_IL, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].tk);
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_instret", i), instret, vecs[i].ret);
        end

        // Illegal-opcode halt must hold regardless of inputs.
        for (int i = 0; i < 20; i++) begin
            step(0, ADDI, 1, i[0]);
            chk($sformatf("halt_hold%0d", i), 32'(outs()), 32'(H_IL));
        end

        // Reset recovers from HALT.
        step(1, ADDI, 1, 0);
        chk("halt_rst", 32'(outs()), 32'(ZERO));
        step(0, ADDI, 0, 0);
        chk("rec_idle", 32'(outs()), 32'(ZERO));
        step(0, ADDI, 0, 0);
        chk("rec_fetch", 32'(outs()), 32'(F_WT));

        // Reset mid-fetch drops mem_req without waiting for a clock edge.
        #2 rst = 1'b1;
        #1 chk("async_req", {31'd0, mem_req}, 32'd0);
        chk("async_state", {29'd0, state}, 32'd0);

        // Reset during WRITEBACK: the instruction is not retired.
        step(0, ADDI, 1, 0);
        step(0, ADDI, 1, 0);
        step(0, ADDI, 1, 0);
        step(0, ADDI, 1, 0);
        step(0, ADDI, 1, 0);
        chk("wb_before_rst", 32'(outs()), 32'(W_AL));
        #2 rst = 1'b1;
        @(posedge clk);
        #1 chk("wb_rst_instret", instret, 32'd0);
        chk("wb_rst_state", {29'd0, state}, 32'd0);

`ifdef CTRL_TIMEOUT_EN
        // 15 unanswered fetch cycles, then HALT with fault=10.
        step(0, ADDI, 0, 0);
        for (int i = 0; i < 15; i++) begin
            step(0, ADDI, 0, 0);
            chk($sformatf("to_wait%0d", i), 32'(outs()), 32'(F_WT));
        end
        step(0, ADDI, 0, 0);
        chk("to_halt", 32'(outs()), 32'(H_TO));
        // Ready arriving in the 15th waiting cycle wins over the timeout.
        step(1, ADDI, 0, 0);
        step(0, ADDI, 0, 0);
        for (int i = 0; i < 14; i++) step(0, ADDI, 0, 0);
        step(0, ADDI, 1, 0);
        chk("to_ready15", 32'(outs()), 32'(F_RD));
        step(0, ADDI, 1, 0);
        chk("to_no_fault", 32'(outs()), 32'(DEC));
`else
        // Without the timeout, FETCH waits indefinitely.
        step(0, ADDI, 0, 0);
        for (int i = 0; i < 40; i++) step(0, ADDI, 0, 0);
        chk("no_to_wait", 32'(outs()), 32'(F_WT));
        step(0, ADDI, 1, 0);
        chk("no_to_ready", 32'(outs()), 32'(F_RD));
        step(0, ADDI, 1, 0);
        chk("no_to_dec", 32'(outs()), 32'(DEC));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32I core. Consumes the 7-bit opcode from the instruction decoder and drives the load and select strobes for the IR, PC, ALU, memory port and register file across FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It owns the single shared memory port through a req/ready handshake, counts retired instructions, and halts on faults.

Parameters:
TIMEOUT_CYCLES, 15, maximum cycles a memory request may stay unacknowledged before fault; counter width is $clog2(TIMEOUT_CYCLES+1)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instruction[6:0] from decoder, stable from DECODE until next FETCH
branch_taken  in  1  ALU compare result, valid in EXECUTE
mem_ready  in  1  memory acknowledges current request this cycle
mem_req  out  1  memory request
mem_we  out  1  1 = store, 0 = read
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_write  out  1  load instruction register
mdr_write  out  1  load memory data register
pc_write  out  1  load PC
pc_src  out  2  00 PC+4, 01 PC+imm (branch/jal), 10 ALU result (jalr)
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = imm
reg_write  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 MDR, 10 PC+4, 11 imm (lui)
state  out  3  current state encoding
halted  out  1  core stopped
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout, 11 ecall/ebreak
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Clock clk, reset rst: one clock; reset is asynchronous and active-high. Reset forces state=IDLE, fault=00, instret=0, wait counter=0.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6. All outputs decode combinationally from registered state, opcode and mem_ready; unlisted strobes are 0.
- IDLE: all strobes 0; next cycle -> FETCH. IDLE is present only after reset.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. If mem_ready, assert ir_write in the same cycle and go to DECODE; otherwise stay in FETCH.
- DECODE: one cycle. Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Any other opcode -> HALT with fault=01. Otherwise -> EXECUTE.
- EXECUTE, one cycle, dispatched by opcode:
  - OP/OP-IMM: alu_a_sel=0, alu_b_sel=(OP-IMM); -> WRITEBACK.
  - LUI: -> WRITEBACK.
  - AUIPC: alu_a_sel=1, alu_b_sel=1; -> WRITEBACK.
  - LOAD/STORE: alu_b_sel=1; -> MEM.
  - BRANCH: pc_write=1, pc_src=branch_taken?01:00; retire; -> FETCH.
  - JAL: -> WRITEBACK.
  - JALR: alu_b_sel=1; -> WRITEBACK.
  - FENCE: pc_write=1, pc_src=00; retire; -> FETCH.
  - SYSTEM: -> HALT with fault=11.
- MEM: mem_req=1, mem_addr_sel=1, alu_b_sel=1, mem_we=(STORE). On mem_ready: a store asserts pc_write with pc_src=00, retires, -> FETCH; a load asserts mdr_write, -> WRITEBACK.
- WRITEBACK: reg_write=1 and pc_write=1. Selects by opcode:
  - wb_sel: LUI 11; LOAD 01; JAL/JALR 10; others 00.
  - pc_src: JAL 01; JALR 10; others 00.
  - Retire, -> FETCH. A destination of x0 is filtered by the register file, not here.
- Retire: instret increments by 1 on the clock edge that leaves the retiring state. It wraps from all-ones to 0.
- Wait counter: clears on entry to FETCH or MEM and increments each cycle mem_req=1 with mem_ready=0. If it reaches TIMEOUT_CYCLES while still waiting -> HALT with fault=10. If mem_ready arrives in the same cycle the count reaches the limit, mem_ready wins and there is no fault.
- HALT: halted=1, all strobes 0, fault held. Only rst exits HALT.
- rst mid-transaction: mem_req drops asynchronously. The interrupted instruction is not retired.

Optional Feature:
CTRL_TIMEOUT_EN:
- Defined: the wait counter and the timeout fault (fault=10) are present.
- Undefined: the counter is not built, FETCH/MEM wait indefinitely for mem_ready, and fault never takes the value 10.

Test Plan:
- Reset release -> state=0 for 1 cycle, then 1 with mem_req=1; outputs all zero while rst=1.
- ADDI (opcode 0010011), mem_ready=1 immediately -> FETCH, DECODE, EXECUTE, WRITEBACK = 4 cycles; reg_write=1, wb_sel=00 and pc_write=1 in cycle 4; instret 0->1.
- LW with mem_ready delayed 3 cycles in MEM -> mdr_write pulses once with ready, then WRITEBACK with wb_sel=01; total 8 cycles.
- BEQ with branch_taken=1, then BNE with branch_taken=0 -> pc_src 01 then 00 in EXECUTE; neither asserts reg_write.
- Opcode 1111111 -> HALT after DECODE, fault=01, halted=1; held for 20 cycles; rst recovers.
- With CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> HALT with fault=10 after 15 waiting cycles. Ready on cycle 15 -> no fault.
